// File: rtl/backprop_seq_engine_if.sv
// Handshake, neuron-memory and error-contribution signals of backprop_seq_engine.
// slave = engine side, master = sequencer/memory side.
interface backprop_seq_engine_if #(
  parameter int unsigned N_INPUTS = 32,
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned ADDR_W   = $clog2(N_INPUTS + 1)
);
  logic                  bp_start;
  logic [DATA_W-1:0]     bp_axon;
  logic [DATA_W-1:0]     bp_backprop;
  logic [DATA_W-1:0]     bp_training_ratio;
  logic                  bp_busy;
  logic                  bp_done;
  logic                  bp_rd_en;
  logic [ADDR_W-1:0]     bp_rd_addr;
  logic [2*DATA_W-1:0]   bp_rd_data;
  logic                  bp_wr_en;
  logic [ADDR_W-1:0]     bp_wr_addr;
  logic [DATA_W-1:0]     bp_wr_data;
  logic                  bp_chg_valid;
  logic [ADDR_W-1:0]     bp_chg_idx;
  logic [DATA_W-1:0]     bp_chg_data;

  modport slave (
    input  bp_start, bp_axon, bp_backprop, bp_training_ratio, bp_rd_data,
    output bp_busy, bp_done, bp_rd_en, bp_rd_addr, bp_wr_en, bp_wr_addr, bp_wr_data,
           bp_chg_valid, bp_chg_idx, bp_chg_data
  );

  modport master (
    output bp_start, bp_axon, bp_backprop, bp_training_ratio, bp_rd_data,
    input  bp_busy, bp_done, bp_rd_en, bp_rd_addr, bp_wr_en, bp_wr_addr, bp_wr_data,
           bp_chg_valid, bp_chg_idx, bp_chg_data
  );
endinterface

// File: rtl/backprop_seq_engine.sv
// Time-multiplexed fixed-point back-propagation for one neuron: delta once, then one weight per cycle.
// Define BP_SATURATE_EN to clamp every narrowing instead of two's-complement wrap.
module backprop_seq_engine #(
  parameter int unsigned N_INPUTS = 32,
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned FRAC_W   = 12,
  parameter int unsigned ADDR_W   = $clog2(N_INPUTS + 1)
) (
  input logic                  clk,
  input logic                  rst_n,
  backprop_seq_engine_if.slave bp
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(N_INPUTS);
  localparam logic signed [DATA_W-1:0] ONE =
    {{(DATA_W-FRAC_W-1){1'b0}}, 1'b1, {FRAC_W{1'b0}}};

  typedef enum logic [2:0] {StIdle, StD1, StD2, StD3, StScan, StDone} state_e;

  function automatic logic signed [DATA_W-1:0] narrow(input logic signed [2*DATA_W-1:0] v);
`ifdef BP_SATURATE_EN
    logic signed [2*DATA_W-1:0] sat_max, sat_min;
    sat_max = {{(DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    sat_min = {{(DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
    if (v > sat_max) return sat_max[DATA_W-1:0];
    if (v < sat_min) return sat_min[DATA_W-1:0];
    return v[DATA_W-1:0];
`else
    return v[DATA_W-1:0];
`endif
  endfunction

  function automatic logic signed [DATA_W-1:0] mul(input logic signed [DATA_W-1:0] a,
                                                   input logic signed [DATA_W-1:0] b);
    logic signed [2*DATA_W-1:0] p;
    p = {{DATA_W{a[DATA_W-1]}}, a} * {{DATA_W{b[DATA_W-1]}}, b};
    return narrow(p >>> FRAC_W);
  endfunction

  function automatic logic signed [DATA_W-1:0] add(input logic signed [DATA_W-1:0] a,
                                                   input logic signed [DATA_W-1:0] b,
                                                   input logic                     sub);
    logic signed [DATA_W:0] s;
    s = sub ? ({a[DATA_W-1], a} - {b[DATA_W-1], b}) : ({a[DATA_W-1], a} + {b[DATA_W-1], b});
    return narrow({{(DATA_W-1){s[DATA_W]}}, s});
  endfunction

  state_e                    state_q;
  logic signed [DATA_W-1:0]  axon_q, backprop_q, ratio_q;
  logic signed [DATA_W-1:0]  d_q, delta_q, step_q;
  logic                      vld1_q;
  logic [ADDR_W-1:0]         idx1_q;

  logic signed [DATA_W-1:0]  rd_w, rd_dend, dend_eff, chg_c, wnew_c;

  // Memory data for idx1_q is present this cycle; bias entry uses ONE as its dendrite.
  always_comb begin
    rd_w     = $signed(bp.bp_rd_data[DATA_W-1:0]);
    rd_dend  = $signed(bp.bp_rd_data[2*DATA_W-1:DATA_W]);
    dend_eff = (idx1_q == LAST) ? ONE : rd_dend;
    chg_c    = mul(delta_q, rd_w);
    wnew_c   = add(rd_w, mul(step_q, dend_eff), 1'b0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= StIdle;
      axon_q          <= '0;
      backprop_q      <= '0;
      ratio_q         <= '0;
      d_q             <= '0;
      delta_q         <= '0;
      step_q          <= '0;
      vld1_q          <= 1'b0;
      idx1_q          <= '0;
      bp.bp_busy      <= 1'b0;
      bp.bp_done      <= 1'b0;
      bp.bp_rd_en     <= 1'b0;
      bp.bp_rd_addr   <= '0;
      bp.bp_wr_en     <= 1'b0;
      bp.bp_wr_addr   <= '0;
      bp.bp_wr_data   <= '0;
      bp.bp_chg_valid <= 1'b0;
      bp.bp_chg_idx   <= '0;
      bp.bp_chg_data  <= '0;
    end else begin
      bp.bp_done      <= 1'b0;
      bp.bp_wr_en     <= 1'b0;
      bp.bp_chg_valid <= 1'b0;
      vld1_q          <= bp.bp_rd_en;
      idx1_q          <= bp.bp_rd_addr;

      if (vld1_q) begin
        bp.bp_wr_en   <= 1'b1;
        bp.bp_wr_addr <= idx1_q;
        bp.bp_wr_data <= wnew_c;
        if (idx1_q != LAST) begin
          bp.bp_chg_valid <= 1'b1;
          bp.bp_chg_idx   <= idx1_q;
          bp.bp_chg_data  <= chg_c;
        end
      end

      unique case (state_q)
        StIdle: begin
          if (bp.bp_start) begin
            axon_q     <= $signed(bp.bp_axon);
            backprop_q <= $signed(bp.bp_backprop);
            ratio_q    <= $signed(bp.bp_training_ratio);
            bp.bp_busy <= 1'b1;
            state_q    <= StD1;
          end
        end
        StD1: begin
          d_q     <= mul(axon_q, add(ONE, axon_q, 1'b1));
          state_q <= StD2;
        end
        StD2: begin
          delta_q <= mul(backprop_q, d_q);
          state_q <= StD3;
        end
        StD3: begin
          step_q        <= mul(ratio_q, delta_q);
          bp.bp_rd_en   <= 1'b1;
          bp.bp_rd_addr <= '0;
          state_q       <= StScan;
        end
        StScan: begin
          if (bp.bp_rd_en) begin
            if (bp.bp_rd_addr == LAST) bp.bp_rd_en <= 1'b0;
            else bp.bp_rd_addr <= bp.bp_rd_addr + 1'b1;
          end
          // Scan ends once the bias write is on the outputs.
          if (bp.bp_wr_en && bp.bp_wr_addr == LAST) begin
            bp.bp_busy <= 1'b0;
            bp.bp_done <= 1'b1;
            state_q    <= StDone;
          end
        end
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
